// File: rtl/aqed_pkg.sv
// -----------------------------------------------------------------------------
// aqed_pkg
//   Shared definitions for the A-QED output checker: default widths, the
//   transaction counter type and the checker FSM state encoding.
// -----------------------------------------------------------------------------
package aqed_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int CNT_WIDTH_DEF  = 17;

   typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ORIG = 2'd1,
      WAIT_DUP  = 2'd2,
      DONE      = 2'd3
   } state_e;

endpackage

// File: rtl/aqed_txn_counter.sv
// -----------------------------------------------------------------------------
// aqed_txn_counter
//   Saturating up-counter used for the input, output and post-original
//   acceptance counts. Sticks at all-ones instead of wrapping.
//
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   en_i    increment request (caller folds in clock enable)
//   clr_i   synchronous clear, wins over en_i
//   cnt_o   current count
//   sat_o   count is at all-ones
// -----------------------------------------------------------------------------
module aqed_txn_counter #(
   parameter int W = 17
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o,
   output logic         sat_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign sat_o = &cnt_q;
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !sat_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/aqed_out_checker.sv
// -----------------------------------------------------------------------------
// aqed_out_checker
//   Receive-side half of A-QED. Watches the DUT output stream, captures the
//   output belonging to the original input, compares it with the output of
//   the duplicate input and reports the verdict. Outputs are assumed to come
//   back in acceptance order, so output N belongs to accepted input N.
//
// Ports:
//   clk, reset (sync, active-low), clk_en (global enable), flush (clear check)
//   in_acc / in_is_orig / in_is_dup   accepted-input stream and its tags
//   out_valid / out_data              DUT output stream
//   qed_done, qed_check               verdict (check meaningful once done)
//   resp_timeout, proto_err           sticky error flags
//   orig_data                         captured original output (debug)
// -----------------------------------------------------------------------------
module aqed_out_checker
   import aqed_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int RESP_BOUND = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  flush,
   input  logic                  in_acc,
   input  logic                  in_is_orig,
   input  logic                  in_is_dup,
   input  logic                  out_valid,
   input  logic [DATA_WIDTH-1:0] out_data,
   output logic                  qed_done,
   output logic                  qed_check,
   output logic                  resp_timeout,
   output logic                  proto_err,
   output logic [DATA_WIDTH-1:0] orig_data
);

   // Timeout fires on the acceptance that brings after_orig up to RESP_BOUND.
   localparam logic [CNT_WIDTH-1:0] BOUND_M1 = CNT_WIDTH'(RESP_BOUND - 1);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  orig_idx_q, orig_idx_d;
   logic [CNT_WIDTH-1:0]  dup_idx_q, dup_idx_d;
   logic                  dup_vld_q, dup_vld_d;
   logic                  orig_cap_q, orig_cap_d;
   logic [DATA_WIDTH-1:0] orig_data_q, orig_data_d;
   logic                  done_q, done_d;
   logic                  check_q, check_d;
   logic                  to_q, to_d;
   logic                  perr_q, perr_d;

   logic [CNT_WIDTH-1:0]  in_cnt, out_cnt, ao_cnt;
   logic                  in_sat, out_sat, ao_sat;

   logic orig_flag, dup_flag, both_flag;
   logic flush_eff, cap_orig, dup_hit;
   logic ao_inc, ao_clr, to_now, proto_now;

   // ---------------------------------------------------------------- counters
   aqed_txn_counter #(.W(CNT_WIDTH)) u_in_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (clk_en & in_acc),
      .clr_i  (1'b0),
      .cnt_o  (in_cnt),
      .sat_o  (in_sat)
   );

   aqed_txn_counter #(.W(CNT_WIDTH)) u_out_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (clk_en & out_valid),
      .clr_i  (1'b0),
      .cnt_o  (out_cnt),
      .sat_o  (out_sat)
   );

   // Acceptances since the original, counted only while its output is pending.
   aqed_txn_counter #(.W(CNT_WIDTH)) u_after_orig (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (ao_inc),
      .clr_i  (ao_clr),
      .cnt_o  (ao_cnt),
      .sat_o  (ao_sat)
   );

   // ------------------------------------------------------------- qualifiers
   assign both_flag = in_acc & in_is_orig & in_is_dup;
   assign orig_flag = in_acc & in_is_orig & ~in_is_dup;
   assign dup_flag  = in_acc & in_is_dup & ~in_is_orig;

   // Flush only acts mid-check; in IDLE there is nothing to clear and DONE
   // must keep its verdict.
   assign flush_eff = flush & ((state_q == WAIT_ORIG) | (state_q == WAIT_DUP));

   assign cap_orig = (state_q == WAIT_ORIG) & ~orig_cap_q & out_valid &
                     (out_cnt == orig_idx_q) & ~flush_eff;
   assign dup_hit  = (state_q == WAIT_DUP) & out_valid &
                     (out_cnt == dup_idx_q) & ~flush_eff;

   assign ao_inc = clk_en & (state_q == WAIT_ORIG) & ~orig_cap_q & in_acc & ~flush_eff;
   assign ao_clr = clk_en & ((state_q == IDLE) | flush_eff);

   // An original output arriving on the same cycle still counts as in time.
   assign to_now = ao_inc & ((ao_cnt >= BOUND_M1) | ao_sat) & ~cap_orig;

   assign proto_now = both_flag
                    | (orig_flag & (state_q != IDLE))
                    | (dup_flag & ((state_q == IDLE) | dup_vld_q))
                    | (out_valid & (out_cnt >= in_cnt))
                    | in_sat | out_sat;

   // -------------------------------------------------------------------- FSM
   always_comb begin
      state_d     = state_q;
      orig_idx_d  = orig_idx_q;
      dup_idx_d   = dup_idx_q;
      dup_vld_d   = dup_vld_q;
      orig_cap_d  = orig_cap_q;
      orig_data_d = orig_data_q;
      done_d      = done_q;
      check_d     = check_q;
      to_d        = to_q | to_now;
      perr_d      = perr_q | proto_now;

      if (flush_eff) begin
         state_d     = IDLE;
         orig_idx_d  = '0;
         dup_idx_d   = '0;
         dup_vld_d   = 1'b0;
         orig_cap_d  = 1'b0;
         orig_data_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (orig_flag) begin
                  orig_idx_d = in_cnt;
                  state_d    = WAIT_ORIG;
               end
            end
            WAIT_ORIG: begin
               if (dup_flag && !dup_vld_q) begin
                  dup_idx_d = in_cnt;
                  dup_vld_d = 1'b1;
               end
               if (cap_orig) begin
                  orig_data_d = out_data;
                  orig_cap_d  = 1'b1;
               end
               if (orig_cap_d && dup_vld_d)
                  state_d = WAIT_DUP;
            end
            WAIT_DUP: begin
               if (dup_hit) begin
                  done_d  = 1'b1;
                  check_d = (out_data == orig_data_q);
                  state_d = DONE;
               end
            end
            default: ; // DONE holds until reset
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         orig_idx_q  <= '0;
         dup_idx_q   <= '0;
         dup_vld_q   <= 1'b0;
         orig_cap_q  <= 1'b0;
         orig_data_q <= '0;
         done_q      <= 1'b0;
         check_q     <= 1'b0;
         to_q        <= 1'b0;
         perr_q      <= 1'b0;
      end else if (clk_en) begin
         state_q     <= state_d;
         orig_idx_q  <= orig_idx_d;
         dup_idx_q   <= dup_idx_d;
         dup_vld_q   <= dup_vld_d;
         orig_cap_q  <= orig_cap_d;
         orig_data_q <= orig_data_d;
         done_q      <= done_d;
         check_q     <= check_d;
         to_q        <= to_d;
         perr_q      <= perr_d;
      end
   end

   assign qed_done     = done_q;
   assign qed_check    = check_q;
   assign resp_timeout = to_q;
   assign proto_err    = perr_q;
   assign orig_data    = orig_data_q;

endmodule

// File: tb/tb_aqed_out_checker.sv
// -----------------------------------------------------------------------------
// tb_aqed_out_checker
//   Directed scenarios plus a randomized run, checked every cycle against a
//   transaction-level reference model (indices, flags, captured data).
// -----------------------------------------------------------------------------
module tb_aqed_out_checker;
   import aqed_pkg::*;

   localparam int DW = 16;
   localparam int CW = 17;
   localparam int RB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          clk_en = 1'b1;
   logic          flush = 1'b0;
   logic          in_acc = 1'b0;
   logic          in_is_orig = 1'b0;
   logic          in_is_dup = 1'b0;
   logic          out_valid = 1'b0;
   logic [DW-1:0] out_data = '0;
   logic          qed_done, qed_check, resp_timeout, proto_err;
   logic [DW-1:0] orig_data;

   always #5 clk = ~clk;

   aqed_out_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .RESP_BOUND(RB)) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .flush        (flush),
      .in_acc       (in_acc),
      .in_is_orig   (in_is_orig),
      .in_is_dup    (in_is_dup),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .qed_done     (qed_done),
      .qed_check    (qed_check),
      .resp_timeout (resp_timeout),
      .proto_err    (proto_err),
      .orig_data    (orig_data)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Transaction view: index of the original / duplicate (-1 = none), whether
   // the original's output has been seen, and the sticky verdict flags.
   int            m_in, m_out, m_oidx, m_didx, m_after;
   bit            m_ogot, m_done, m_chk, m_to, m_perr;
   logic [DW-1:0] m_odata;

   function automatic int m_phase();
      if (m_done)                  return 3;
      if (m_oidx < 0)              return 0;
      if (m_ogot && m_didx >= 0)   return 2;
      return 1;
   endfunction

   function automatic void m_clear();
      m_in = 0; m_out = 0; m_oidx = -1; m_didx = -1; m_after = 0;
      m_ogot = 0; m_done = 0; m_chk = 0; m_to = 0; m_perr = 0; m_odata = '0;
   endfunction

   function automatic void model_step();
      int  p;
      bit  fl, cap, og0;
      if (!reset) begin
         m_clear();
         return;
      end
      if (!clk_en) return;
      p   = m_phase();
      fl  = flush && (p == 1 || p == 2);
      og0 = m_ogot;
      cap = 0;
      if (in_acc) begin
         if (in_is_orig && in_is_dup) m_perr = 1;
         else if (in_is_orig) begin
            if (p == 0) begin m_oidx = m_in; m_after = 0; end
            else m_perr = 1;
         end else if (in_is_dup) begin
            if (p == 0 || m_didx >= 0) m_perr = 1;
            else if (!fl) m_didx = m_in;
         end
      end
      if (out_valid) begin
         if (m_out >= m_in) m_perr = 1;
         if (!fl && p == 1 && !og0 && m_out == m_oidx) begin
            m_ogot = 1; m_odata = out_data; cap = 1;
         end
         if (!fl && p == 2 && m_out == m_didx) begin
            m_done = 1; m_chk = (out_data == m_odata);
         end
      end
      if (!fl && p == 1 && !og0 && in_acc) begin
         m_after++;
         if (!cap && m_after >= RB) m_to = 1;
      end
      if (fl) begin
         m_oidx = -1; m_didx = -1; m_ogot = 0; m_odata = '0; m_after = 0;
      end
      if (in_acc)    m_in++;
      if (out_valid) m_out++;
   endfunction

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("qed_done",     qed_done,     m_done);
      chk("qed_check",    qed_check,    m_chk);
      chk("resp_timeout", resp_timeout, m_to);
      chk("proto_err",    proto_err,    m_perr);
      chk("orig_data",    orig_data,    m_odata);
      chk("state",        32'(dut.state_q), m_phase());
      chk("in_cnt",       32'(dut.in_cnt),  m_in);
      chk("out_cnt",      32'(dut.out_cnt), m_out);
   endtask

   task automatic drive(input bit ia, input bit io, input bit idp, input bit ov,
                        input logic [DW-1:0] od);
      in_acc = ia; in_is_orig = io; in_is_dup = idp; out_valid = ov; out_data = od;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0; clk_en = 1'b1; flush = 1'b0;
      drive(0, 0, 0, 0, '0);
      drive(0, 0, 0, 0, '0);
      reset = 1'b1;
   endtask

   task automatic match_run(input logic [DW-1:0] dup_val, input bit exp_chk, input string nm);
      do_reset();
      for (int i = 0; i < 8; i++) drive(1, i == 2, i == 5, 0, '0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 1, (i == 2) ? 16'hA5A5 : (i == 5) ? dup_val : 16'(i) * 16'h0111);
         if (i == 4) chk({nm, "_pre_done"}, qed_done, 0);
         if (i == 5) begin
            chk({nm, "_done"},  qed_done,  1);
            chk({nm, "_check"}, qed_check, exp_chk);
            chk({nm, "_odata"}, orig_data, 16'hA5A5);
         end
      end
   endtask

   initial begin
      logic [DW-1:0] pool [3];
      pool[0] = 16'hA5A5; pool[1] = 16'hA5A4; pool[2] = 16'h1234;
      m_clear();

      // reset state
      do_reset();
      chk("rst_done", qed_done, 0);
      chk("rst_perr", proto_err, 0);
      chk("rst_odata", orig_data, 0);

      // match / mismatch
      match_run(16'hA5A5, 1'b1, "match");
      match_run(16'hA5A4, 1'b0, "mismatch");

      // response bound
      do_reset();
      drive(1, 1, 0, 0, '0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, '0);
         if (i == 2) chk("to_early", resp_timeout, 0);
         if (i == 3) chk("to_fire",  resp_timeout, 1);
      end
      chk("to_nodone", qed_done, 0);

      // protocol errors
      do_reset();
      drive(1, 1, 1, 0, '0);
      chk("proto_both", proto_err, 1);
      chk("proto_both_st", 32'(dut.state_q), 0);
      drive(0, 0, 0, 0, '0);
      drive(1, 0, 1, 0, '0);
      chk("proto_dup_idle", proto_err, 1);
      chk("proto_dup_st", 32'(dut.state_q), 0);

      // clock enable and flush
      do_reset();
      drive(1, 1, 0, 0, '0);
      drive(1, 0, 1, 0, '0);
      drive(0, 0, 0, 1, 16'hA5A5);
      chk("ce_wdup", 32'(dut.state_q), 2);
      clk_en = 1'b0;
      repeat (3) drive(0, 0, 0, 1, 16'h5555);
      chk("ce_in_cnt",  32'(dut.in_cnt),  2);
      chk("ce_out_cnt", 32'(dut.out_cnt), 1);
      clk_en = 1'b1;
      flush = 1'b1;
      drive(0, 0, 0, 0, '0);
      flush = 1'b0;
      chk("flush_st", 32'(dut.state_q), 0);
      chk("flush_odata", orig_data, 0);
      drive(0, 0, 0, 1, 16'h5555);
      drive(1, 1, 0, 0, '0);
      drive(1, 0, 1, 0, '0);
      drive(0, 0, 0, 1, 16'h1234);
      drive(0, 0, 0, 1, 16'h1234);
      chk("reflow_done",  qed_done,  1);
      chk("reflow_check", qed_check, 1);

      // reset mid-run with clock enable low
      do_reset();
      drive(1, 1, 0, 0, '0);
      drive(1, 0, 1, 0, '0);
      drive(1, 1, 1, 0, '0);
      drive(0, 0, 0, 1, 16'hA5A5);
      chk("mid_pre_perr", proto_err, 1);
      clk_en = 1'b0; reset = 1'b0;
      drive(0, 0, 0, 0, '0);
      reset = 1'b1; clk_en = 1'b1;
      chk("mid_perr",  proto_err, 0);
      chk("mid_odata", orig_data, 0);
      chk("mid_st",    32'(dut.state_q), 0);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit ia, io, idp, ov;
         reset  = ($urandom_range(0, 149) != 0);
         clk_en = ($urandom_range(0, 9) != 0);
         flush  = ($urandom_range(0, 49) == 0);
         ia  = $urandom_range(0, 1) != 0;
         io  = ia && ($urandom_range(0, 5) == 0);
         idp = ia && ($urandom_range(0, 5) == 0);
         ov  = (m_out < m_in) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
         drive(ia, io, idp, ov, pool[$urandom_range(0, 2)]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/aqed_out_checker.md
Name: aqed_out_checker

Overview:
- Receive-side companion to the A-QED input issuer; sits on the memory_core output stream (data_out / valid_out).
- Tracks which accepted input was the "original" and which the "duplicate", captures the DUT output produced for each, and compares them.
- Drives qed_done/qed_check for the top-level assertion and flags response-bound violations.
- Outputs appear in acceptance order (FIFO / rate-matched mode); the block relies on this.

Parameters:
- DATA_WIDTH, 16, width of DUT output data.
- CNT_WIDTH, 17, width of input/output transaction counters.
- RESP_BOUND, 64, accepted inputs after the original by which the original's output must have appeared.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- clk_en  in  1  global clock enable; no state changes when 0, except reset.
- flush  in  1  synchronous clear of the check state (not the counters); honoured only when clk_en=1.
- in_acc  in  1  one input accepted by the DUT this cycle (wen to DUT).
- in_is_orig  in  1  the accepted input is the original; qualified by in_acc.
- in_is_dup  in  1  the accepted input is the duplicate; qualified by in_acc.
- out_valid  in  1  DUT output valid.
- out_data  in  DATA_WIDTH  DUT output data.
- qed_done  out  1  comparison complete (sticky).
- qed_check  out  1  original and duplicate outputs matched; meaningful when qed_done=1.
- resp_timeout  out  1  sticky response-bound violation.
- proto_err  out  1  sticky issuer protocol error.
- orig_data  out  DATA_WIDTH  captured original output, for debug.

Behaviour:
- Reset (reset==0 at a clk edge): counters=0, state=IDLE, every output 0.
- in_cnt increments on in_acc; out_cnt increments on out_valid. Both saturate at all-ones, and saturation sets proto_err.
- Index of a transaction = in_cnt value before increment, i.e. the first input is index 0.
- FSM, advanced only when clk_en=1:
  - IDLE: on in_acc&in_is_orig, latch orig_idx=in_cnt, go WAIT_ORIG.
  - WAIT_ORIG: on in_acc&in_is_dup, latch dup_idx=in_cnt. On out_valid with out_cnt==orig_idx, capture orig_data. Go WAIT_DUP once the original is captured and dup_idx is latched.
  - WAIT_DUP: on out_valid with out_cnt==dup_idx, set qed_check=(out_data==orig_data) and qed_done=1, go DONE.
  - DONE: terminal; hold qed_done/qed_check until reset.
- Capture and compare latency: qed_done and qed_check are registered one cycle after the matching out_valid.
- Original and duplicate flags in the same cycle, or a duplicate flag while in IDLE: proto_err=1, state unchanged.
- A second original or duplicate flag after its index is latched: proto_err=1; the first latched index is kept.
- Original output and duplicate acceptance in the same cycle: both are recorded, then go WAIT_DUP.
- Response bound: after_orig counts in_acc cycles from WAIT_ORIG entry until the original output is captured.
  - resp_timeout=1 when after_orig>=RESP_BOUND and the original is still not captured.
- flush in WAIT_ORIG or WAIT_DUP: return to IDLE, clear latched indices and orig_data. qed_done, resp_timeout and proto_err are not cleared.
- flush in DONE is ignored.
- Reset mid-operation: full clear to the reset values, regardless of clk_en.
- out_valid with no outstanding input (out_cnt>=in_cnt before increment): proto_err=1.

Decomposition:
- Shared package aqed_pkg:
  - state enum {IDLE, WAIT_ORIG, WAIT_DUP, DONE};
  - DATA_WIDTH and CNT_WIDTH defaults;
  - typedef cnt_t.
- One sub-module, aqed_txn_counter: saturating counter with enable, clear and sat flag. Instantiate it for in_cnt, out_cnt and after_orig.
- FSM and comparator stay in the top.

Test Plan:
- Match: 8 inputs accepted, original at index 2, duplicate at 5. Outputs echo 0xA5A5 at indices 2 and 5. -> qed_done=1 and qed_check=1 one cycle after the 6th out_valid.
- Mismatch: as Match, but output index 5 = 0xA5A4. -> qed_done=1, qed_check=0; orig_data=0xA5A5.
- Timeout: RESP_BOUND=4, original at index 0, 4 further inputs accepted, no out_valid. -> resp_timeout=1 on the cycle after the 4th post-original acceptance; qed_done stays 0.
- Protocol: in_is_orig and in_is_dup asserted together with in_acc. -> proto_err=1, state IDLE. A later duplicate flag while still in IDLE keeps proto_err=1 and leaves the state in IDLE.
- clk_en/flush: clk_en=0 for 3 cycles while out_valid=1 -> counters unchanged. Then flush in WAIT_DUP -> state IDLE and orig_data=0. A new original/duplicate pair then completes normally.
- Reset mid-run: reset=0 for one cycle in WAIT_DUP with clk_en=0. -> all outputs 0, state IDLE next cycle.
